// File: rtl/alu_iter.sv
// Multi-cycle integer execution unit: single-cycle base ALU plus iterative
// shift-add multiplier and restoring divider behind valid/ready channels.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       func3,
    input  logic             mode_flag,
    input  logic             mext,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] rd,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   opa_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q;
    logic               rneg_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   rd_q;

    logic               accept_s;
    logic [SHW-1:0]     shamt_s;
    logic [WIDTH-1:0]   alu_s;
    logic               sgn1_s, sgn2_s, neg1_s, neg2_s;
    logic [WIDTH-1:0]   mag1_s, mag2_s;
    logic               is_mul_s, is_div_s, div_zero_s, div_ovf_s;
    logic [WIDTH-1:0]   fast_res_s;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_sh_s, div_diff_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   iter_res_s;

    assign req_ready  = !rst && !flush &&
                        ((state_q == S_IDLE) || ((state_q == S_DONE) && resp_ready));
    assign accept_s   = req_valid && req_ready;
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
    assign rd         = rd_q;
    assign shamt_s    = rs2[SHW-1:0];

    // Request decode: base ALU result, operand magnitudes and divide fast path.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (func3)
            3'b000:  alu_s = mode_flag ? (rs1 - rs2) : (rs1 + rs2);
            3'b001:  alu_s = rs1 << shamt_s;
            3'b010:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            3'b011:  alu_s = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
            3'b100:  alu_s = rs1 ^ rs2;
            3'b101:  alu_s = mode_flag ? $unsigned($signed(rs1) >>> shamt_s) : (rs1 >> shamt_s);
            3'b110:  alu_s = rs1 | rs2;
            3'b111:  alu_s = rs1 & rs2;
            default: alu_s = {WIDTH{1'b0}};
        endcase

        is_mul_s = mext && !func3[2];
        is_div_s = mext && func3[2];
        // DIV/REM are signed on both sides; MULH signs both, MULHSU only rs1.
        if (func3[2]) begin
            sgn1_s = !func3[0];
            sgn2_s = !func3[0];
        end else begin
            sgn1_s = (func3 == 3'b001) || (func3 == 3'b010);
            sgn2_s = (func3 == 3'b001);
        end
        neg1_s = sgn1_s && rs1[WIDTH-1];
        neg2_s = sgn2_s && rs2[WIDTH-1];
        mag1_s = neg1_s ? (-rs1) : rs1;
        mag2_s = neg2_s ? (-rs2) : rs2;

        div_zero_s = (rs2 == {WIDTH{1'b0}});
        div_ovf_s  = !func3[0] && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == {WIDTH{1'b1}});
        if (div_zero_s) begin
            fast_res_s = func3[1] ? rs1 : {WIDTH{1'b1}};
        end else begin
            fast_res_s = func3[1] ? {WIDTH{1'b0}} : rs1;
        end
    end

    // One engine step on the shared accumulator, plus the sign-corrected final result.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
        div_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s = div_sh_s - {1'b0, opa_q};
        div_ge_s   = (div_sh_s >= {1'b0, opa_q});

        if (state_q == S_DIV) begin
            acc_d = div_ge_s ? {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                             : {div_sh_s[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end

        mul_prod_s = neg_q ? (-acc_d) : acc_d;
        quo_s      = acc_d[WIDTH-1:0];
        rem_s      = acc_d[2*WIDTH-1:WIDTH];

        if (state_q == S_MUL) begin
            iter_res_s = (op_q == 2'b00) ? mul_prod_s[WIDTH-1:0] : mul_prod_s[2*WIDTH-1:WIDTH];
        end else if (op_q[1]) begin
            iter_res_s = rneg_q ? (-rem_s) : rem_s;
        end else begin
            iter_res_s = neg_q ? (-quo_s) : quo_s;
        end
    end

    // Control FSM with operand latching and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {SHW{1'b0}};
            opa_q   <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            op_q    <= 2'b00;
            rd_q    <= {WIDTH{1'b0}};
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        op_q   <= func3[1:0];
                        neg_q  <= neg1_s ^ neg2_s;
                        rneg_q <= neg1_s;
                        if (is_mul_s) begin
                            opa_q   <= mag1_s;
                            acc_q   <= {{WIDTH{1'b0}}, mag2_s};
                            cnt_q   <= SHW'(WIDTH - 1);
                            state_q <= S_MUL;
                        end else if (is_div_s && (div_zero_s || div_ovf_s)) begin
                            rd_q    <= fast_res_s;
                            state_q <= S_DONE;
                        end else if (is_div_s) begin
                            opa_q   <= mag2_s;
                            acc_q   <= {{WIDTH{1'b0}}, mag1_s};
                            cnt_q   <= SHW'(WIDTH - 1);
                            state_q <= S_DIV;
                        end else begin
                            rd_q    <= alu_s;
                            state_q <= S_DONE;
                        end
                    end else if ((state_q == S_DONE) && resp_ready) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == {SHW{1'b0}}) begin
                        rd_q    <= iter_res_s;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (WIDTH=32) with hand-computed results.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  func3;
    logic        mode_flag;
    logic        mext;
    logic [31:0] rs1, rs2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] rd;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    alu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .func3(func3), .mode_flag(mode_flag), .mext(mext),
        .rs1(rs1), .rs2(rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .rd(rd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic m, input logic x,
                         input logic [31:0] a, input logic [31:0] b);
        func3 = f; mode_flag = m; mext = x; rs1 = a; rs2 = b; req_valid = 1'b1;
    endtask

    // Single-cycle op (base or divide fast path): result one cycle after accept.
    task automatic run_one(input string tag, input logic [2:0] f, input logic m, input logic x,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        drive(f, m, x, a, b);
        tick();
        req_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check(tag, rd, exp);
        tick();
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // Iterative op: busy right after accept, result exactly 33 cycles later.
    task automatic run_iter(input string tag, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int lat;
        drive(f, 1'b0, 1'b1, a, b);
        tick();
        req_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_resp(lat);
        check({tag, "_lat"}, lat, 32'd33);
        check(tag, rd, exp);
        tick();
    endtask

    typedef struct {
        logic [2:0]  f;
        logic        m;
        logic [31:0] a, b, e;
    } vec_t;

    initial begin
        int lat;
        vec_t b2b [3];
        rst = 1'b1; flush = 1'b0; resp_ready = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        tick();
        check("rst_rd", rd, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Base operations
        run_one("sub",  3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE);
        run_one("add",  3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
        run_one("sll",  3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'd33, 32'h0000_0002);
        run_one("slt",  3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_one("sltu", 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_one("xor",  3'b100, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        run_one("srl",  3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_one("sra",  3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd36, 32'hF800_0000);
        run_one("or",   3'b110, 1'b0, 1'b0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF);
        run_one("and",  3'b111, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);

        // Iterative multiply and divide
        run_iter("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_iter("mul",    3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
        run_iter("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_iter("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_iter("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_iter("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_iter("divu",   3'b101, 32'd100, 32'd7, 32'd14);
        run_iter("remu",   3'b111, 32'd100, 32'd7, 32'd2);

        // Divide fast paths
        run_one("divu_zero", 3'b101, 1'b0, 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
        run_one("rem_zero",  3'b110, 1'b0, 1'b1, 32'd9, 32'd0, 32'd9);
        run_one("div_ovf",   3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_one("rem_ovf",   3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Backpressure after a MUL, then ADD accepted with resp_ready
        resp_ready = 1'b0;
        drive(3'b000, 1'b0, 1'b1, 32'd6, 32'd7);
        tick();
        req_valid = 1'b0;
        wait_resp(lat);
        check("bp_lat", lat, 32'd33);
        drive(3'b000, 1'b0, 1'b0, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rd", rd, 32'd42);
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("bp_add_valid", {31'd0, resp_valid}, 32'd1);
        check("bp_add", rd, 32'd7);

        // Back-to-back base ops, one result per cycle
        b2b[0] = '{f: 3'b000, m: 1'b0, a: 32'd10, b: 32'd20, e: 32'd30};
        b2b[1] = '{f: 3'b100, m: 1'b0, a: 32'hFF, b: 32'h0F, e: 32'hF0};
        b2b[2] = '{f: 3'b000, m: 1'b1, a: 32'd1, b: 32'd2, e: 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            drive(b2b[i].f, b2b[i].m, 1'b0, b2b[i].a, b2b[i].b);
            tick();
            check("b2b_valid", {31'd0, resp_valid}, 32'd1);
            check("b2b", rd, b2b[i].e);
        end
        req_valid = 1'b0;
        tick();

        // Flush ten cycles into a DIV, with a simultaneous request that must drop
        drive(3'b101, 1'b0, 1'b1, 32'd100, 32'd3);
        tick();
        drive(3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
        req_valid = 1'b0;
        repeat (9) tick();
        check("fl_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        req_valid = 1'b1;
        #1;
        check("fl_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        check("fl_valid", {31'd0, resp_valid}, 32'd0);
        check("fl_busy", {31'd0, busy}, 32'd0);
        repeat (40) tick();
        check("fl_no_resp", {31'd0, resp_valid}, 32'd0);

        // Reset ten cycles into a MUL; rd must drop back to zero
        drive(3'b011, 1'b0, 1'b1, 32'd5, 32'd9);
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        check("rs_rd_before", rd, 32'hFFFF_FFFF);
        rst = 1'b1;
        #1;
        check("rs_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        check("rs_rd", rd, 32'd0);
        check("rs_valid", {31'd0, resp_valid}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        repeat (40) tick();
        check("rs_no_resp", {31'd0, resp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
